alu_issue: RTL

- Command-side initiator for the ALU: accepts packed ALU commands over a valid/ready stream and decodes them into ALU control fields (op, form, vec, copy_neg, copy_select).
- Registers operands A–D onto the ALU ports, captures Y1/Y2 and returns tagged results over a second valid/ready stream.
- Sits between the instruction sequencer and the combinational ALU; the ALU is instantiated inside this block.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_issue_if.sv | 32 +++
 rtl/alu.sv | 75 +++++++
 rtl/alu_cmd_decode.sv | 29 ++
 rtl/alu_issue.sv | 122 ++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command path: op codes, instruction layout, control bundle.
// Latency: none, declarations and a pure function only.
// Backpressure: not applicable.
package alu_pkg;

   localparam int DATA_W  = 32;
   localparam int INSTR_W = 12;

   // Instruction layout, MSB first: {copy_select, copy_neg, vec, form, op, rsvd}
   localparam int RSVD_POS  = 0;
   localparam int OP_LSB    = 1;
   localparam int OP_W      = 3;
   localparam int FORM_POS  = 4;
   localparam int VEC_LSB   = 5;
   localparam int VEC_W     = 2;
   localparam int CNEG_POS  = 7;
   localparam int CSEL_LSB  = 8;
   localparam int CSEL_W    = 4;

   localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
   localparam logic [OP_W-1:0] OP_COPY = 3'b010;
   localparam logic [OP_W-1:0] OP_SUB  = 3'b100;

   // Lane width selected by vec: 0 -> 8 bit, 1 -> 16 bit, 2/3 -> 32 bit
   localparam logic [VEC_W-1:0] VEC_8  = 2'd0;
   localparam logic [VEC_W-1:0] VEC_16 = 2'd1;

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic              form;
      logic [VEC_W-1:0]  vec;
      logic              copy_neg;
      logic [CSEL_W-1:0] copy_select;
   } alu_ctrl_t;

   function automatic logic is_legal_op(input logic [OP_W-1:0] op);
      logic legal;
      case (op)
         OP_ADD, OP_COPY, OP_SUB: legal = 1'b1;
         default:                 legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Command and result streams between the sequencer and the ALU issue block.
// Latency: wires only.
// Backpressure: valid/ready on both streams; master drives commands, slave drives results.
interface alu_issue_if #(parameter int TAG_W = 4);

   logic                        cmd_valid;
   logic                        cmd_ready;
   logic [alu_pkg::INSTR_W-1:0] cmd_instr;
   logic [TAG_W-1:0]            cmd_tag;
   logic [alu_pkg::DATA_W-1:0]  cmd_a;
   logic [alu_pkg::DATA_W-1:0]  cmd_b;
   logic [alu_pkg::DATA_W-1:0]  cmd_c;
   logic [alu_pkg::DATA_W-1:0]  cmd_d;

   logic                        res_valid;
   logic                        res_ready;
   logic [alu_pkg::DATA_W-1:0]  res_y1;
   logic [alu_pkg::DATA_W-1:0]  res_y2;
   logic [TAG_W-1:0]            res_tag;
   logic                        res_err;

   modport master (
      output cmd_valid, cmd_instr, cmd_tag, cmd_a, cmd_b, cmd_c, cmd_d, res_ready,
      input  cmd_ready, res_valid, res_y1, res_y2, res_tag, res_err
   );

   modport slave (
      input  cmd_valid, cmd_instr, cmd_tag, cmd_a, cmd_b, cmd_c, cmd_d, res_ready,
      output cmd_ready, res_valid, res_y1, res_y2, res_tag, res_err
   );

endinterface

// File: rtl/alu.sv
// Combinational two-result ALU: add/sub in pairwise or three-operand form, scaled copy with optional negate.
// Latency: combinational.
// Backpressure: none; outputs follow inputs.
module alu
   import alu_pkg::*;
(
   input  alu_ctrl_t         ctrl,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] c,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] y1,
   output logic [DATA_W-1:0] y2
);

   logic [DATA_W-1:0] src;
   logic [DATA_W-1:0] scaled;
   logic [DATA_W-1:0] raw1;
   logic [DATA_W-1:0] raw2;
   logic [DATA_W-1:0] lane_mask;

   // Operation select. form=0 pairs lanes (A op C, B op D); form=1 chains A op B op C into both results.
   // Copy takes the operand picked by copy_select[3:2], scales it by 4**copy_select[1:0] on Y1
   // (negated if copy_neg) and passes the raw operand on Y2. Results are truncated to the vec lane width.
   always_comb begin
      case (ctrl.copy_select[3:2])
         2'd0:    src = a;
         2'd1:    src = b;
         2'd2:    src = c;
         default: src = d;
      endcase
      scaled = src << {ctrl.copy_select[1:0], 1'b0};

      raw1 = '0;
      raw2 = '0;
      case (ctrl.op)
         OP_ADD: begin
            if (ctrl.form) begin
               raw1 = a + b + c;
               raw2 = raw1;
            end else begin
               raw1 = a + c;
               raw2 = b + d;
            end
         end
         OP_SUB: begin
            if (ctrl.form) begin
               raw1 = a - b - c;
               raw2 = raw1;
            end else begin
               raw1 = a - c;
               raw2 = b - d;
            end
         end
         OP_COPY: begin
            raw1 = ctrl.copy_neg ? (DATA_W'(0) - scaled) : scaled;
            raw2 = src;
         end
         default: begin
            raw1 = '0;
            raw2 = '0;
         end
      endcase

      case (ctrl.vec)
         VEC_8:   lane_mask = 32'h0000_00FF;
         VEC_16:  lane_mask = 32'h0000_FFFF;
         default: lane_mask = 32'hFFFF_FFFF;
      endcase

      y1 = raw1 & lane_mask;
      y2 = raw2 & lane_mask;
   end

endmodule

// File: rtl/alu_cmd_decode.sv
// Splits a packed ALU instruction into control fields and flags unsupported op codes.
// Latency: combinational.
// Backpressure: none; pure decode.
module alu_cmd_decode
   import alu_pkg::*;
(
   input  logic [INSTR_W-1:0] instr,
   output alu_ctrl_t          ctrl,
   output logic               illegal
);

   // The reserved bit carries no meaning; it is deliberately dropped here.
   logic unused_rsvd;
   assign unused_rsvd = instr[RSVD_POS];

   // Field extraction; an illegal op yields an all-zero control word so the ALU idles as a plain add.
   always_comb begin
      ctrl    = '0;
      illegal = !is_legal_op(instr[OP_LSB +: OP_W]);
      if (!illegal) begin
         ctrl.op          = instr[OP_LSB +: OP_W];
         ctrl.form        = instr[FORM_POS];
         ctrl.vec         = instr[VEC_LSB +: VEC_W];
         ctrl.copy_neg    = instr[CNEG_POS];
         ctrl.copy_select = instr[CSEL_LSB +: CSEL_W];
      end
   end

endmodule

// File: rtl/alu_issue.sv
// Issues decoded commands to the ALU and returns tagged Y1/Y2 results; counts accepted commands.
// Latency: result valid two cycles after command acceptance, one command per cycle sustained.
// Backpressure: res_ready low freezes S2; S1 then holds and cmd_ready drops once S1 is occupied.
module alu_issue
   import alu_pkg::*;
#(
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
)
(
   input  logic             clk,
   input  logic             rst,
   alu_issue_if.slave       io,
   output logic [CNT_W-1:0] issued_cnt
);

   alu_ctrl_t         dec_ctrl;
   logic              dec_illegal;

   logic              s1_valid;
   alu_ctrl_t         s1_ctrl;
   logic [DATA_W-1:0] s1_a;
   logic [DATA_W-1:0] s1_b;
   logic [DATA_W-1:0] s1_c;
   logic [DATA_W-1:0] s1_d;
   logic [TAG_W-1:0]  s1_tag;
   logic              s1_err;

   logic              s2_valid;
   logic [DATA_W-1:0] s2_y1;
   logic [DATA_W-1:0] s2_y2;
   logic [TAG_W-1:0]  s2_tag;
   logic              s2_err;

   logic [DATA_W-1:0] alu_y1;
   logic [DATA_W-1:0] alu_y2;

   logic              adv;
   logic              accept;

   // S2 can take new content when it is empty or its result leaves this cycle.
   assign adv         = !s2_valid || io.res_ready;
   // S1 can take a command when empty or when it empties into S2 this cycle; no dependence on cmd_valid.
   assign io.cmd_ready = !s1_valid || adv;
   assign accept      = io.cmd_valid && io.cmd_ready;

   assign io.res_valid = s2_valid;
   assign io.res_y1    = s2_y1;
   assign io.res_y2    = s2_y2;
   assign io.res_tag   = s2_tag;
   assign io.res_err   = s2_err;

   alu_cmd_decode u_decode (
      .instr   (io.cmd_instr),
      .ctrl    (dec_ctrl),
      .illegal (dec_illegal)
   );

   alu u_alu (
      .ctrl (s1_ctrl),
      .a    (s1_a),
      .b    (s1_b),
      .c    (s1_c),
      .d    (s1_d),
      .y1   (alu_y1),
      .y2   (alu_y2)
   );

   // S1: capture decoded command and operands; illegal commands drive zero operands so the ALU yields zeros.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_ctrl  <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_c     <= '0;
         s1_d     <= '0;
         s1_tag   <= '0;
         s1_err   <= 1'b0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_ctrl  <= dec_ctrl;
         s1_a     <= dec_illegal ? '0 : io.cmd_a;
         s1_b     <= dec_illegal ? '0 : io.cmd_b;
         s1_c     <= dec_illegal ? '0 : io.cmd_c;
         s1_d     <= dec_illegal ? '0 : io.cmd_d;
         s1_tag   <= io.cmd_tag;
         s1_err   <= dec_illegal;
      end else if (adv) begin
         s1_valid <= 1'b0;
      end
   end

   // S2: latch ALU results when the output slot is free; data is left untouched while empty or stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_y1    <= '0;
         s2_y2    <= '0;
         s2_tag   <= '0;
         s2_err   <= 1'b0;
      end else if (adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_y1  <= alu_y1;
            s2_y2  <= alu_y2;
            s2_tag <= s1_tag;
            s2_err <= s1_err;
         end
      end
   end

   // Saturating count of accepted commands, illegal ones included.
   always_ff @(posedge clk) begin
      if (rst) begin
         issued_cnt <= '0;
      end else if (accept && (issued_cnt != '1)) begin
         issued_cnt <= issued_cnt + CNT_W'(1);
      end
   end

endmodule
